// File: rtl/transmission_estimator_pipe_pkg.sv
// Shared definitions for the transmission estimator datapath.
//
// Holds the Q0.16 reference constants (ONE, default omega and T0) and
// the per-lane beat layout carried from the scaling stage to the
// clamp stage: {scaled, t0}.
package transmission_estimator_pipe_pkg;

    localparam int unsigned TE_WIDTH_Q16  = 16;
    localparam logic [15:0] TE_ONE_Q16    = 16'hFFFF;
    localparam int unsigned TE_OMEGA_INIT = 62259;  // 0.95 in Q0.16
    localparam int unsigned TE_T0_INIT    = 19661;  // 0.3 in Q0.16

    // Per-lane beat at Q0.16; the top declares the same layout at its WIDTH.
    typedef struct packed {
        logic [TE_WIDTH_Q16-1:0] scaled;
        logic [TE_WIDTH_Q16-1:0] t0;
    } te_beat_t;

endpackage

// File: rtl/transmission_lane.sv
// One lane of the clamp stage: T = ONE - scaled, replaced by T0 when the
// result would fall below T0 (scaled > ONE - T0, unsigned, WIDTH bits).
//
// Ports:
//   scaled_i   - omega * min(Pc/Ac), already shifted down to Q0.WIDTH
//   t0_i       - lower bound that travelled with this beat
//   t_o        - transmission estimate, Q0.WIDTH
//   clamped_o  - 1 when t0_i was substituted
module transmission_lane
    import transmission_estimator_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = TE_WIDTH_Q16
) (
    input  logic [WIDTH-1:0] scaled_i,
    input  logic [WIDTH-1:0] t0_i,
    output logic [WIDTH-1:0] t_o,
    output logic             clamped_o
);

    localparam logic [WIDTH-1:0] ONE = '1;

    logic [WIDTH-1:0] limit;

    always_comb begin
        limit     = ONE - t0_i;
        clamped_o = (scaled_i > limit);
        t_o       = clamped_o ? t0_i : (ONE - scaled_i);
    end

endmodule

// File: rtl/transmission_estimator_pipe.sv
// Two-stage pipelined transmission estimator, T = ONE - omega * x, with a
// T0 lower bound, LANES pixels per beat under one valid/ready handshake.
//
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   in_valid/in_ready      - input handshake; in_data lane 0 in LSBs
//   out_valid/out_ready    - output handshake; out_data is T per lane
//   out_clamped            - per-lane flag, T0 substituted
//   cfg_we/cfg_omega/cfg_t0- runtime omega and T0 update
//   cnt_clr, clamp_cnt     - saturating count of clamped output lanes
//
// S1 holds {scaled, t0} per lane; S2 holds the final out_data/out_clamped.
// omega/T0 are sampled at S1 acceptance, so a config write only affects
// beats accepted after the write edge.
module transmission_estimator_pipe
    import transmission_estimator_pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = TE_WIDTH_Q16,
    parameter int unsigned LANES      = 1,
    parameter int unsigned OMEGA_INIT = TE_OMEGA_INIT,
    parameter int unsigned T0_INIT    = TE_T0_INIT,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_clamped,
    input  logic                   cfg_we,
    input  logic [WIDTH-1:0]       cfg_omega,
    input  logic [WIDTH-1:0]       cfg_t0,
    input  logic                   cnt_clr,
    output logic [CNT_W-1:0]       clamp_cnt
);

    localparam int unsigned POP_W = $clog2(LANES + 1);

    typedef struct packed {
        logic [WIDTH-1:0] scaled;
        logic [WIDTH-1:0] t0;
    } beat_t;

    beat_t [LANES-1:0]            s1_beat_d;
    beat_t [LANES-1:0]            s1_beat_q;
    logic                         s1_valid_q;
    logic                         s2_valid_q;
    logic [WIDTH-1:0]             omega_q;
    logic [WIDTH-1:0]             t0_q;
    logic [LANES-1:0][WIDTH-1:0]  lane_t;
    logic [LANES-1:0]             lane_clamped;
    logic [LANES*WIDTH-1:0]       out_data_q;
    logic [LANES-1:0]             out_clamped_q;
    logic [CNT_W-1:0]             clamp_cnt_q;
    logic [CNT_W-1:0]             clamp_cnt_d;
    logic [CNT_W-1:0]             cnt_base;
    logic [CNT_W:0]               cnt_sum;
    logic [POP_W-1:0]             pop;
    logic                         s1_can_load;
    logic                         s2_can_load;
    logic                         in_fire;
    logic                         out_fire;

    // No skid buffer: in_ready is combinational from out_ready.
    assign s2_can_load = !s2_valid_q || out_ready;
    assign s1_can_load = !s1_valid_q || s2_can_load;
    assign in_fire     = in_valid && s1_can_load;
    assign out_fire    = s2_valid_q && out_ready;

    assign in_ready    = s1_can_load;
    assign out_valid   = s2_valid_q;
    assign out_data    = out_data_q;
    assign out_clamped = out_clamped_q;
    assign clamp_cnt   = clamp_cnt_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [WIDTH-1:0] scaled;
        logic [WIDTH-1:0] frac_unused;

        // Full 2*WIDTH product; the low half is truncated away.
        assign {scaled, frac_unused} = {{WIDTH{1'b0}}, in_data[g*WIDTH +: WIDTH]}
                                     * {{WIDTH{1'b0}}, omega_q};
        assign s1_beat_d[g] = {scaled, t0_q};

        transmission_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .scaled_i  (s1_beat_q[g].scaled),
            .t0_i      (s1_beat_q[g].t0),
            .t_o       (lane_t[g]),
            .clamped_o (lane_clamped[g])
        );
    end

    // A clear in the same cycle as a handshake drops only the old count.
    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            pop = pop + POP_W'(out_clamped_q[i]);
        end
        cnt_base    = cnt_clr ? '0 : clamp_cnt_q;
        cnt_sum     = {1'b0, cnt_base} + (CNT_W+1)'(pop);
        clamp_cnt_d = clamp_cnt_q;
        if (out_fire) begin
            clamp_cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end else if (cnt_clr) begin
            clamp_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s2_valid_q    <= 1'b0;
            s1_beat_q     <= '0;
            omega_q       <= WIDTH'(OMEGA_INIT);
            t0_q          <= WIDTH'(T0_INIT);
            out_data_q    <= '0;
            out_clamped_q <= '0;
            clamp_cnt_q   <= '0;
        end else begin
            if (cfg_we) begin
                omega_q <= cfg_omega;
                t0_q    <= cfg_t0;
            end
            if (s1_can_load) begin
                s1_valid_q <= in_valid;
                if (in_fire) begin
                    s1_beat_q <= s1_beat_d;
                end
            end
            if (s2_can_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q    <= lane_t;
                    out_clamped_q <= lane_clamped;
                end
            end
            clamp_cnt_q <= clamp_cnt_d;
        end
    end

endmodule

// File: tb/tb_transmission_estimator_pipe.sv
module tb_transmission_estimator_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT A: single lane, default counter width
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_out_data;
    logic [0:0]  a_out_clamped;
    logic        a_cfg_we, a_cnt_clr;
    logic [15:0] a_cfg_omega, a_cfg_t0;
    logic [31:0] a_clamp_cnt;

    // DUT B: four lanes, 4-bit counter
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_in_data, b_out_data;
    logic [3:0]  b_out_clamped;
    logic        b_cfg_we, b_cnt_clr;
    logic [15:0] b_cfg_omega, b_cfg_t0;
    logic [3:0]  b_clamp_cnt;

    transmission_estimator_pipe #(
        .WIDTH(16), .LANES(1), .OMEGA_INIT(62259), .T0_INIT(19661), .CNT_W(32)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_clamped(a_out_clamped),
        .cfg_we(a_cfg_we), .cfg_omega(a_cfg_omega), .cfg_t0(a_cfg_t0),
        .cnt_clr(a_cnt_clr), .clamp_cnt(a_clamp_cnt)
    );

    transmission_estimator_pipe #(
        .WIDTH(16), .LANES(4), .OMEGA_INIT(62259), .T0_INIT(19661), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_clamped(b_out_clamped),
        .cfg_we(b_cfg_we), .cfg_omega(b_cfg_omega), .cfg_t0(b_cfg_t0),
        .cnt_clr(b_cnt_clr), .clamp_cnt(b_clamp_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: T = ONE - (x*w >> 16), clamped to t0 when below it.
    function automatic logic [16:0] t_model(input logic [15:0] x, input logic [15:0] w,
                                            input logic [15:0] t0);
        logic [31:0] p;
        logic [15:0] s;
        p = {16'd0, x} * {16'd0, w};
        s = p[31:16];
        if (s > 16'hFFFF - t0) return {1'b1, t0};
        return {1'b0, 16'hFFFF - s};
    endfunction

    // Scoreboards
    logic [16:0] a_q[$];
    logic [16:0] a_obs[$];
    logic [67:0] b_q[$];
    logic [15:0] m_omega = 16'd62259;
    logic [15:0] m_t0    = 16'd19661;

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_in_valid && a_in_ready)
                a_q.push_back(t_model(a_in_data, m_omega, m_t0));
            if (a_cfg_we) begin
                m_omega = a_cfg_omega;
                m_t0    = a_cfg_t0;
            end
            if (a_out_valid && a_out_ready) begin
                logic [16:0] e;
                a_obs.push_back({a_out_clamped, a_out_data});
                check("a_sb_nonempty", 64'(a_q.size() != 0), 64'd1);
                if (a_q.size() != 0) begin
                    e = a_q.pop_front();
                    check("a_sb_data", 64'(a_out_data), 64'(e[15:0]));
                    check("a_sb_clamped", 64'(a_out_clamped), 64'(e[16]));
                end
            end
            if (b_in_valid && b_in_ready) begin
                logic [67:0] be;
                logic [16:0] le;
                be = '0;
                for (int i = 0; i < 4; i++) begin
                    le = t_model(b_in_data[i*16 +: 16], 16'd62259, 16'd19661);
                    be[i*16 +: 16] = le[15:0];
                    be[64 + i]     = le[16];
                end
                b_q.push_back(be);
            end
            if (b_out_valid && b_out_ready) begin
                logic [67:0] be;
                check("b_sb_nonempty", 64'(b_q.size() != 0), 64'd1);
                if (b_q.size() != 0) begin
                    be = b_q.pop_front();
                    check("b_sb_data", b_out_data, be[63:0]);
                    check("b_sb_clamped", 64'(b_out_clamped), 64'(be[67:64]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 4-lane beat through B; optional cnt_clr during its output handshake.
    task automatic b_run(input logic [63:0] d, input logic clr,
                         output logic [63:0] od, output logic [3:0] oc);
        b_in_valid = 1'b1;
        b_in_data  = d;
        step();
        b_in_valid = 1'b0;
        step();
        check("b_out_valid", 64'(b_out_valid), 64'd1);
        od = b_out_data;
        oc = b_out_clamped;
        b_cnt_clr = clr;
        step();
        b_cnt_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] bp_vals[8] = '{16'd100, 16'd48289, 16'd48290, 16'd20000,
                                    16'd65535, 16'd7, 16'd40000, 16'd1234};
        int          sat_exp[5] = '{6, 10, 14, 15, 15};
        logic [63:0] od;
        logic [3:0]  oc;
        int          waited;

        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_out_ready = 1;
        a_cfg_we = 0; a_cfg_omega = 0; a_cfg_t0 = 0; a_cnt_clr = 0;
        b_in_valid = 0; b_in_data = 0; b_out_ready = 1;
        b_cfg_we = 0; b_cfg_omega = 0; b_cfg_t0 = 0; b_cnt_clr = 0;
        step();
        step();

        // Reset state
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_clamped", 64'(a_out_clamped), 64'd0);
        check("rst_clamp_cnt", 64'(a_clamp_cnt), 64'd0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        rst_n = 1'b1;
        step();

        // Streamed 0, 32768, 65535 with defaults
        a_in_valid = 1; a_in_data = 16'd0;
        step();
        check("lat_not_yet_valid", 64'(a_out_valid), 64'd0);
        a_in_data = 16'd32768;
        step();
        check("stream0_valid", 64'(a_out_valid), 64'd1);
        check("stream0_data", 64'(a_out_data), 64'd65535);
        check("stream0_clamped", 64'(a_out_clamped), 64'd0);
        a_in_data = 16'd65535;
        step();
        a_in_valid = 0;
        check("stream1_data", 64'(a_out_data), 64'd34406);
        check("stream1_clamped", 64'(a_out_clamped), 64'd0);
        step();
        check("stream2_data", 64'(a_out_data), 64'd19661);
        check("stream2_clamped", 64'(a_out_clamped), 64'd1);
        step();
        check("stream_drained", 64'(a_out_valid), 64'd0);
        check("stream_clamp_cnt", 64'(a_clamp_cnt), 64'd1);

        // Backpressure: 5 cycles of out_ready=0 in the middle of a stream
        a_obs.delete();
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic acc;
                    acc = 1'b0;
                    a_in_valid = 1'b1;
                    a_in_data  = bp_vals[k];
                    for (int t = 0; t < 50 && !acc; t++) begin
                        @(negedge clk);
                        acc = a_in_ready;
                        step();
                    end
                    check("bp_accept", 64'(acc), 64'd1);
                end
                a_in_valid = 1'b0;
            end
            begin
                logic [16:0] held;
                logic        saw_low;
                saw_low = 1'b0;
                held    = '0;
                step(); step(); step();
                a_out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check("bp_valid_held", 64'(a_out_valid), 64'd1);
                    if (c == 0) held = {a_out_clamped, a_out_data};
                    else check("bp_data_stable", 64'({a_out_clamped, a_out_data}), 64'(held));
                    if (!a_in_ready) saw_low = 1'b1;
                    step();
                end
                check("bp_in_ready_fell", 64'(saw_low), 64'd1);
                a_out_ready = 1'b1;
            end
        join
        waited = 0;
        while (a_q.size() != 0 && waited < 50) begin
            step();
            waited++;
        end
        step(); step();
        check("bp_drained", 64'(a_q.size()), 64'd0);
        check("bp_beats_out", 64'(a_obs.size()), 64'd8);

        // Config write in the same cycle as an accepted beat
        a_obs.delete();
        a_in_valid = 1; a_in_data = 16'd65535;
        a_cfg_we = 1; a_cfg_omega = 16'd32768; a_cfg_t0 = 16'd0;
        step();
        a_cfg_we = 0;
        a_in_data = 16'd65535;
        step();
        a_in_valid = 0;
        step(); step(); step();
        check("cfg_beats_out", 64'(a_obs.size()), 64'd2);
        if (a_obs.size() >= 2) begin
            check("cfg_old_values", 64'(a_obs[0]), 64'({1'b1, 16'd19661}));
            check("cfg_new_values", 64'(a_obs[1]), 64'({1'b0, 16'd32768}));
        end

        // Four lanes: lane0..3 = 65535, 0, 65535, 32768
        b_run({16'd32768, 16'd65535, 16'd0, 16'd65535}, 1'b0, od, oc);
        check("b4_data", od, {16'd34406, 16'd19661, 16'd65535, 16'd19661});
        check("b4_clamped", 64'(oc), 64'(4'b0101));
        check("b4_clamp_cnt", 64'(b_clamp_cnt), 64'd2);

        // Clear together with a 2-clamp handshake
        b_run({16'd32768, 16'd65535, 16'd0, 16'd65535}, 1'b1, od, oc);
        check("b_clr_with_fire", 64'(b_clamp_cnt), 64'd2);

        // All-clamped beats drive the 4-bit counter into saturation
        for (int k = 0; k < 5; k++) begin
            b_run({4{16'd65535}}, 1'b0, od, oc);
            check("b_sat_clamped", 64'(oc), 64'hF);
            check("b_sat_cnt", 64'(b_clamp_cnt), 64'(sat_exp[k]));
        end

        // Clear with no handshake
        b_cnt_clr = 1'b1;
        step();
        b_cnt_clr = 1'b0;
        check("b_clr_alone", 64'(b_clamp_cnt), 64'd0);

        // Reset with two beats in flight
        a_out_ready = 1'b0;
        a_in_valid = 1; a_in_data = 16'd0;
        step();
        a_in_data = 16'd100;
        step();
        a_in_valid = 0;
        check("inflight_out_valid", 64'(a_out_valid), 64'd1);
        check("inflight_in_ready", 64'(a_in_ready), 64'd0);
        rst_n = 1'b0;
        step();
        check("midrst_out_valid", 64'(a_out_valid), 64'd0);
        check("midrst_in_ready", 64'(a_in_ready), 64'd1);
        check("midrst_out_data", 64'(a_out_data), 64'd0);
        check("midrst_clamp_cnt", 64'(a_clamp_cnt), 64'd0);
        a_q.delete();
        b_q.delete();
        a_obs.delete();
        m_omega = 16'd62259;
        m_t0    = 16'd19661;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        step(); step(); step();
        check("midrst_no_emit", 64'(a_obs.size()), 64'd0);
        a_in_valid = 1; a_in_data = 16'd65535;
        step();
        a_in_valid = 0;
        step();
        check("midrst_defaults_data", 64'(a_out_data), 64'd19661);
        check("midrst_defaults_clamped", 64'(a_out_clamped), 64'd1);
        step(); step();
        check("final_a_sb_empty", 64'(a_q.size()), 64'd0);
        check("final_b_sb_empty", 64'(b_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/transmission_estimator_pipe.md
# transmission_estimator_pipe

Pipelined, parametrised transmission estimator for the dehaze datapath: computes T(x) = ONE − ω·min(Pc/Ac) with a runtime-programmable ω and lower bound T0 across LANES parallel pixels per beat. It sits between the dark-channel/atmospheric-light ratio stage and the scene-recovery stage. It adds a valid/ready handshake, a two-stage pipeline, per-beat configuration coherence, and a saturating clamp-event counter.

## Interface
- WIDTH, 16, fractional bits of Q0.WIDTH data; ONE = 2^WIDTH − 1
- LANES, 1, pixels per beat; all lanes share one handshake
- OMEGA_INIT, 62259, reset value of ω (0.95 in Q0.16)
- T0_INIT, 19661, reset value of T0 (0.3 in Q0.16)
- CNT_W, 32, clamp-counter width
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  LANES*WIDTH  min(Pc/Ac) per lane, lane 0 in LSBs
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  LANES*WIDTH  T(x) per lane, Q0.WIDTH
- out_clamped  out  LANES  per-lane flag: T0 substituted
- cfg_we  in  1  write ω and T0
- cfg_omega  in  WIDTH  new ω
- cfg_t0  in  WIDTH  new T0
- cnt_clr  in  1  clear clamp counter
- clamp_cnt  out  CNT_W  saturating count of clamped lanes

## Operation
- Stage 1 (S1): on acceptance, per lane prod = in_data·ω (2·WIDTH bits). Register scaled = prod >> WIDTH (truncate, no rounding) together with the current T0.
- Stage 2 (S2): per lane, if scaled > ONE − T0 then out = T0 and clamped = 1; otherwise out = ONE − scaled and clamped = 0. The comparison is unsigned, with ONE − T0 computed at WIDTH bits.
- Config coherence: ω and T0 are latched into the beat at S1 acceptance. The T0 value travels with the beat to S2. A cfg_we in cycle N affects beats accepted in cycle N+1 and later. In-flight beats are never altered.
- If cfg_t0 > ONE − 0, there is no special case. T0 = 0 disables clamping effectively. Only the comparison defines behaviour.
- Clamp counter: at S2 output handshake (out_valid && out_ready), add popcount(out_clamped). The counter saturates at 2^CNT_W − 1. If cnt_clr and a handshake occur in the same cycle, the counter is loaded with that beat's popcount (clear wins over old value only).

## Timing
- Latency: 2 cycles from input acceptance to out_valid, when there is no backpressure.
- Throughput: 1 beat/clk.
- Each stage's register loads when it is empty or the next stage consumes. in_ready = !S1_valid || S2_can_load, where S2_can_load = !S2_valid || out_ready. This is combinational from out_ready; no skid buffer.
- out_data and out_clamped hold stable while out_valid && !out_ready.
- Reset (rst_n = 0 at a clk edge):
  - S1_valid = S2_valid = 0, so out_valid = 0 and in_ready = 1 after reset.
  - out_data = 0, out_clamped = 0, clamp_cnt = 0.
  - ω = OMEGA_INIT, T0 = T0_INIT.
  - Reset mid-stream drops in-flight beats without emitting them.
- in_ready may be 1 during reset release.
- Simultaneous cfg_we and acceptance in the same cycle: the beat uses the old ω/T0.

## Structure
- The shared package holds:
  - Q-format constants: ONE(WIDTH), default OMEGA and T0 for Q0.16.
  - A per-lane beat struct {scaled, t0}.
- Sub-module transmission_lane holds the combinational S2 clamp/subtract for one lane. It is instantiated LANES times by a generate loop. The pipeline, handshake, config and counter logic stay in the top.

## Test plan
- Reset defaults, WIDTH=16, LANES=1, in = 0, 32768, 65535 streamed with out_ready=1:
  - out = 65535, 34406, 19661 (clamped = 0, 0, 1) on cycles +2, +3, +4.
  - clamp_cnt = 1.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream.
  - in_ready falls once both stages are full.
  - out_data is stable; no beat is lost or duplicated; order is preserved.
- Config coherence: cfg_we with ω=32768, T0=0 in the same cycle as accepting in=65535.
  - That beat outputs 19661 (clamped) using the old values.
  - The next beat, in=65535, outputs 65535 − 32767 = 32768.
- LANES=4, in = {65535, 0, 65535, 32768} → out = {19661, 65535, 19661, 34406}, clamped = 4'b0101, clamp_cnt += 2.
- Counter edge cases:
  - Preset the counter near saturation (CNT_W=4) and drive 4-lane all-clamped beats: it sticks at 15.
  - cnt_clr together with a 2-clamp handshake yields 2.
- Reset asserted with 2 beats in flight: out_valid = 0 next cycle, no output emitted, ω/T0 restored to defaults.
